// File: rtl/ex_mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_pkg
// Shared definitions for the EX/MEM stage of the 16-bit 5-stage CPU:
//   - default widths (datapath, register address, ALUCode)
//   - ALUCode opcode constants, NOP=0 .. LOAD=26 (27..31 behave as NOP)
//   - flag register layout {ZF,NF,CF} with ZF at bit 2, CF at bit 0
//   - small decode helpers for write-back and flag-update classes
// ---------------------------------------------------------------------------
package ex_mem_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 3;
    localparam int OP_W_DEF   = 5;

    localparam int FLAG_ZF = 2;
    localparam int FLAG_NF = 1;
    localparam int FLAG_CF = 0;

    typedef logic [OP_W_DEF-1:0] op_t;

    // Packed so that zf lands on bit FLAG_ZF and cf on bit FLAG_CF.
    typedef struct packed {
        logic zf;
        logic nf;
        logic cf;
    } flags_t;

    localparam op_t OP_NOP   = 5'd0;
    localparam op_t OP_HALT  = 5'd1;
    localparam op_t OP_STORE = 5'd2;
    localparam op_t OP_LDIH  = 5'd3;
    localparam op_t OP_ADD   = 5'd4;
    localparam op_t OP_ADDI  = 5'd5;
    localparam op_t OP_ADDC  = 5'd6;
    localparam op_t OP_SUB   = 5'd7;
    localparam op_t OP_SUBI  = 5'd8;
    localparam op_t OP_SUBC  = 5'd9;
    localparam op_t OP_CMP   = 5'd10;
    localparam op_t OP_AND   = 5'd11;
    localparam op_t OP_OR    = 5'd12;
    localparam op_t OP_XOR   = 5'd13;
    localparam op_t OP_SLL   = 5'd14;
    localparam op_t OP_SRL   = 5'd15;
    localparam op_t OP_SLA   = 5'd16;
    localparam op_t OP_SRA   = 5'd17;
    localparam op_t OP_JUMP  = 5'd18;
    localparam op_t OP_JMPR  = 5'd19;
    localparam op_t OP_BZ    = 5'd20;
    localparam op_t OP_BNZ   = 5'd21;
    localparam op_t OP_BN    = 5'd22;
    localparam op_t OP_BNN   = 5'd23;
    localparam op_t OP_BC    = 5'd24;
    localparam op_t OP_BNC   = 5'd25;
    localparam op_t OP_LOAD  = 5'd26;

    // The opcode map keeps the arithmetic/logic group contiguous, so the
    // decode classes reduce to range checks.
    function automatic logic writes_reg(input op_t op);
        return (op == OP_LOAD) ||
               ((op >= OP_LDIH) && (op <= OP_SUBC)) ||
               ((op >= OP_AND)  && (op <= OP_SRA));
    endfunction

    function automatic logic sets_zn(input op_t op);
        return (op >= OP_ADD) && (op <= OP_SRA);
    endfunction

    function automatic logic sets_cf(input op_t op);
        return (op >= OP_ADD) && (op <= OP_CMP);
    endfunction

endpackage

// File: rtl/ex_mem_stage_branch_cond.sv
// ---------------------------------------------------------------------------
// branch_cond
// Combinational branch resolver: decides whether the instruction in EX
// redirects fetch, given the flag register as left by older instructions.
// Ports:
//   alu_code  in   ALUCode of the EX instruction
//   flags     in   {ZF,NF,CF}
//   taken     out  1 = jump / condition satisfied
// ---------------------------------------------------------------------------
module branch_cond
    import ex_mem_stage_pkg::*;
(
    input  op_t    alu_code,
    input  flags_t flags,
    output logic   taken
);

    always_comb begin
        taken = 1'b0;
        case (alu_code)
            OP_JUMP, OP_JMPR: taken = 1'b1;
            OP_BZ:            taken = flags.zf;
            OP_BNZ:           taken = ~flags.zf;
            OP_BN:            taken = flags.nf;
            OP_BNN:           taken = ~flags.nf;
            OP_BC:            taken = flags.cf;
            OP_BNC:           taken = ~flags.cf;
            default:          taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
// EX/MEM pipeline register and flag unit sitting right after the ALU.
// Captures ALU result/store data/destination, decodes memory and write-back
// enables, owns the ZF/NF/CF flag register (CF fed back to the ALU) and
// produces a registered one-cycle branch redirect.
//
// Update priority: r_st > halted > flush > stall > capture/bubble.
//
// Ports:
//   clock, r_st (async, active-low)      clock / reset
//   stall, flush                         hazard-unit controls
//   ex_valid, ex_ALUCode, ex_ALU_out,    EX-stage instruction fields
//   ex_cf, ex_store_data, ex_rd
//   cf_to_alu, flags                     flag register ({ZF,NF,CF})
//   mem_valid, mem_ALUCode, mem_result,  MEM-stage slot
//   mem_store_data, mem_rd
//   mem_reg_we, mem_rd_en, mem_wr_en     decoded enables
//   br_taken, br_target                  fetch redirect (target = mem_result)
//   halted                               sticky after HALT
//
// Optional build macro EXMEM_PERF_CNT_EN adds perf_retired / perf_br_taken
// 16-bit wrapping counters.
// ---------------------------------------------------------------------------
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clock,
    input  logic              r_st,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [OP_W-1:0]   ex_ALUCode,
    input  logic [DATA_W-1:0] ex_ALU_out,
    input  logic              ex_cf,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              cf_to_alu,
    output logic [2:0]        flags,
    output logic              mem_valid,
    output logic [OP_W-1:0]   mem_ALUCode,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_reg_we,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic              halted
`ifdef EXMEM_PERF_CNT_EN
    ,
    output logic [15:0]       perf_retired,
    output logic [15:0]       perf_br_taken
`endif
);

    logic              valid_reg;
    logic [OP_W-1:0]   op_reg;
    logic [DATA_W-1:0] result_reg;
    logic [DATA_W-1:0] store_data_reg;
    logic [REG_AW-1:0] rd_reg;
    logic              reg_we_reg;
    logic              rd_en_reg;
    logic              wr_en_reg;
    logic              br_taken_reg;
    logic              halted_reg;
    flags_t            flags_reg;

    logic              hold;
    logic              capture;
    logic              cond_taken;

    // Once halted, stall and flush no longer matter: the slot drains to bubbles.
    assign hold    = ~halted_reg & ~flush & stall;
    assign capture = ~halted_reg & ~flush & ~stall & ex_valid;

    // Evaluated against the flags already in the register, i.e. those set by
    // the older instruction, never by the one being captured now.
    branch_cond u_branch_cond (
        .alu_code (ex_ALUCode),
        .flags    (flags_reg),
        .taken    (cond_taken)
    );

    always_ff @(posedge clock or negedge r_st) begin
        if (!r_st) begin
            valid_reg      <= 1'b0;
            op_reg         <= OP_NOP;
            result_reg     <= '0;
            store_data_reg <= '0;
            rd_reg         <= '0;
            reg_we_reg     <= 1'b0;
            rd_en_reg      <= 1'b0;
            wr_en_reg      <= 1'b0;
            br_taken_reg   <= 1'b0;
            halted_reg     <= 1'b0;
            flags_reg      <= '0;
        end else if (hold) begin
            // Slot and flags held; the redirect must not repeat.
            br_taken_reg <= 1'b0;
        end else if (capture) begin
            valid_reg      <= 1'b1;
            op_reg         <= ex_ALUCode;
            result_reg     <= ex_ALU_out;
            store_data_reg <= ex_store_data;
            rd_reg         <= ex_rd;
            reg_we_reg     <= writes_reg(ex_ALUCode);
            rd_en_reg      <= (ex_ALUCode == OP_LOAD);
            wr_en_reg      <= (ex_ALUCode == OP_STORE);
            br_taken_reg   <= cond_taken;
            if (ex_ALUCode == OP_HALT) begin
                halted_reg <= 1'b1;
            end
            if (sets_zn(ex_ALUCode)) begin
                flags_reg.zf <= (ex_ALU_out == '0);
                flags_reg.nf <= ex_ALU_out[DATA_W-1];
            end
            if (sets_cf(ex_ALUCode)) begin
                flags_reg.cf <= ex_cf;
            end
        end else begin
            // Bubble: halted, flush, or no valid instruction in EX.
            valid_reg      <= 1'b0;
            op_reg         <= OP_NOP;
            result_reg     <= '0;
            store_data_reg <= '0;
            rd_reg         <= '0;
            reg_we_reg     <= 1'b0;
            rd_en_reg      <= 1'b0;
            wr_en_reg      <= 1'b0;
            br_taken_reg   <= 1'b0;
        end
    end

`ifdef EXMEM_PERF_CNT_EN
    logic [15:0] perf_retired_reg;
    logic [15:0] perf_br_taken_reg;

    always_ff @(posedge clock or negedge r_st) begin
        if (!r_st) begin
            perf_retired_reg  <= '0;
            perf_br_taken_reg <= '0;
        end else if (capture) begin
            perf_retired_reg <= perf_retired_reg + 16'd1;
            if (cond_taken) begin
                perf_br_taken_reg <= perf_br_taken_reg + 16'd1;
            end
        end
    end

    assign perf_retired  = perf_retired_reg;
    assign perf_br_taken = perf_br_taken_reg;
`endif

    assign cf_to_alu      = flags_reg.cf;
    assign flags          = flags_reg;
    assign mem_valid      = valid_reg;
    assign mem_ALUCode    = op_reg;
    assign mem_result     = result_reg;
    assign mem_store_data = store_data_reg;
    assign mem_rd         = rd_reg;
    assign mem_reg_we     = reg_we_reg;
    assign mem_rd_en      = rd_en_reg;
    assign mem_wr_en      = wr_en_reg;
    assign br_taken       = br_taken_reg;
    assign br_target      = result_reg;
    assign halted         = halted_reg;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
// Self-checking bench for ex_mem_stage: a table of directed vectors, hand
// sequences for stall/flush/reset/HALT, then randomized traffic compared
// against a behavioural model of the stage.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

    // Opcode numbering of the CPU (bench-local copy).
    localparam logic [4:0] T_NOP = 5'd0,  T_HALT = 5'd1,  T_STORE = 5'd2,
                           T_LDIH = 5'd3, T_ADD = 5'd4,   T_ADDI = 5'd5,
                           T_ADDC = 5'd6, T_SUB = 5'd7,   T_SUBI = 5'd8,
                           T_SUBC = 5'd9, T_CMP = 5'd10,  T_AND = 5'd11,
                           T_OR = 5'd12,  T_XOR = 5'd13,  T_SLL = 5'd14,
                           T_SRL = 5'd15, T_SLA = 5'd16,  T_SRA = 5'd17,
                           T_JUMP = 5'd18, T_JMPR = 5'd19, T_BZ = 5'd20,
                           T_BNZ = 5'd21, T_BN = 5'd22,   T_BNN = 5'd23,
                           T_BC = 5'd24,  T_BNC = 5'd25,  T_LOAD = 5'd26;

    logic        clock = 1'b0;
    logic        r_st;
    logic        stall, flush, ex_valid, ex_cf;
    logic [4:0]  ex_ALUCode;
    logic [15:0] ex_ALU_out, ex_store_data;
    logic [2:0]  ex_rd;
    logic        cf_to_alu, mem_valid, mem_reg_we, mem_rd_en, mem_wr_en;
    logic        br_taken, halted;
    logic [2:0]  flags, mem_rd;
    logic [4:0]  mem_ALUCode;
    logic [15:0] mem_result, mem_store_data, br_target;
`ifdef EXMEM_PERF_CNT_EN
    logic [15:0] perf_retired, perf_br_taken;
`endif

    ex_mem_stage dut (
        .clock          (clock),
        .r_st           (r_st),
        .stall          (stall),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_ALUCode     (ex_ALUCode),
        .ex_ALU_out     (ex_ALU_out),
        .ex_cf          (ex_cf),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .cf_to_alu      (cf_to_alu),
        .flags          (flags),
        .mem_valid      (mem_valid),
        .mem_ALUCode    (mem_ALUCode),
        .mem_result     (mem_result),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_reg_we     (mem_reg_we),
        .mem_rd_en      (mem_rd_en),
        .mem_wr_en      (mem_wr_en),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .halted         (halted)
`ifdef EXMEM_PERF_CNT_EN
        ,
        .perf_retired   (perf_retired),
        .perf_br_taken  (perf_br_taken)
`endif
    );

    always #5 clock = ~clock;

    int tests  = 0;
    int failed = 0;

    // ---------------- behavioural model ----------------
    bit          m_valid, m_we, m_rden, m_wren, m_br, m_halted;
    bit          m_z, m_n, m_c;
    logic [4:0]  m_op;
    logic [15:0] m_res, m_sd;
    logic [2:0]  m_rd;
    int          m_ret, m_brc;

    function automatic bit writes_back(input logic [4:0] op);
        return op inside {T_LOAD, T_LDIH, T_ADD, T_ADDI, T_ADDC, T_SUB, T_SUBI,
                          T_SUBC, T_AND, T_OR, T_XOR, T_SLL, T_SRL, T_SLA, T_SRA};
    endfunction

    function automatic bit updates_zn(input logic [4:0] op);
        return op inside {T_ADD, T_ADDI, T_ADDC, T_SUB, T_SUBI, T_SUBC, T_CMP,
                          T_AND, T_OR, T_XOR, T_SLL, T_SRL, T_SLA, T_SRA};
    endfunction

    function automatic bit updates_c(input logic [4:0] op);
        return op inside {T_ADD, T_ADDI, T_ADDC, T_SUB, T_SUBI, T_SUBC, T_CMP};
    endfunction

    function automatic bit branch_taken(input logic [4:0] op, input bit z, input bit n, input bit c);
        if (op == T_JUMP || op == T_JMPR) return 1'b1;
        if (op == T_BZ)  return z;
        if (op == T_BNZ) return !z;
        if (op == T_BN)  return n;
        if (op == T_BNN) return !n;
        if (op == T_BC)  return c;
        if (op == T_BNC) return !c;
        return 1'b0;
    endfunction

    task automatic model_bubble();
        m_valid = 0; m_op = T_NOP; m_we = 0; m_rden = 0; m_wren = 0; m_br = 0;
    endtask

    task automatic model_reset();
        model_bubble();
        m_res = 0; m_sd = 0; m_rd = 0; m_halted = 0;
        m_z = 0; m_n = 0; m_c = 0; m_ret = 0; m_brc = 0;
    endtask

    task automatic model_step(input bit s, input bit f, input bit v, input logic [4:0] op,
                              input logic [15:0] alu, input bit c, input logic [15:0] sd,
                              input logic [2:0] rd);
        bit tk;
        if (m_halted || f) model_bubble();
        else if (s) m_br = 0;
        else if (!v) model_bubble();
        else begin
            tk = branch_taken(op, m_z, m_n, m_c);
            m_valid = 1; m_op = op; m_res = alu; m_sd = sd; m_rd = rd;
            m_we = writes_back(op); m_rden = (op == T_LOAD); m_wren = (op == T_STORE);
            m_br = tk;
            if (updates_zn(op)) begin m_z = (alu == 16'h0); m_n = alu[15]; end
            if (updates_c(op)) m_c = c;
            if (op == T_HALT) m_halted = 1;
            m_ret = (m_ret + 1) % 65536;
            if (tk) m_brc = (m_brc + 1) % 65536;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " mem_valid"},  32'(mem_valid),  32'(m_valid));
        check({tag, " mem_reg_we"}, 32'(mem_reg_we), 32'(m_we));
        check({tag, " mem_rd_en"},  32'(mem_rd_en),  32'(m_rden));
        check({tag, " mem_wr_en"},  32'(mem_wr_en),  32'(m_wren));
        check({tag, " br_taken"},   32'(br_taken),   32'(m_br));
        check({tag, " flags"},      32'(flags),      32'({m_z, m_n, m_c}));
        check({tag, " cf_to_alu"},  32'(cf_to_alu),  32'(m_c));
        check({tag, " halted"},     32'(halted),     32'(m_halted));
        if (m_op < 5'd27) check({tag, " mem_ALUCode"}, 32'(mem_ALUCode), 32'(m_op));
        if (m_valid) begin
            check({tag, " mem_result"},     32'(mem_result),     32'(m_res));
            check({tag, " br_target"},      32'(br_target),      32'(m_res));
            check({tag, " mem_store_data"}, 32'(mem_store_data), 32'(m_sd));
            check({tag, " mem_rd"},         32'(mem_rd),         32'(m_rd));
        end
`ifdef EXMEM_PERF_CNT_EN
        check({tag, " perf_retired"},  32'(perf_retired),  32'(m_ret));
        check({tag, " perf_br_taken"}, 32'(perf_br_taken), 32'(m_brc));
`endif
    endtask

    // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input string tag, input bit s, input bit f, input bit v,
                        input logic [4:0] op, input logic [15:0] alu, input bit c,
                        input logic [15:0] sd, input logic [2:0] rd);
        stall = s; flush = f; ex_valid = v; ex_ALUCode = op;
        ex_ALU_out = alu; ex_cf = c; ex_store_data = sd; ex_rd = rd;
        model_step(s, f, v, op, alu, c, sd, rd);
        @(posedge clock);
        #1;
        $display("[TB] %s s=%0d f=%0d v=%0d op=%0d alu=%h -> valid=%0d we=%0d rd_en=%0d wr_en=%0d br=%0d flags=%b res=%h halted=%0d",
                 tag, s, f, v, op, alu, mem_valid, mem_reg_we, mem_rd_en, mem_wr_en,
                 br_taken, flags, mem_result, halted);
    endtask

    // Reset asserted mid-cycle: outputs must clear without waiting for a clock edge.
    task automatic do_reset(input string tag);
        r_st = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        check({tag, " result0"}, 32'(mem_result),     32'h0);
        check({tag, " sdata0"},  32'(mem_store_data), 32'h0);
        check({tag, " rd0"},     32'(mem_rd),         32'h0);
        check({tag, " op0"},     32'(mem_ALUCode),    32'h0);
        @(posedge clock);
        #1;
        r_st = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          s, f, v;
        logic [4:0]  op;
        logic [15:0] alu;
        bit          cf;
        logic [15:0] sd;
        logic [2:0]  rd;
        bit          e_valid, e_we, e_rden, e_wren, e_br;
        logic [2:0]  e_flags;
        logic [15:0] e_res;
        logic [15:0] e_sd;
        logic [2:0]  e_rd;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [4:0] op, input logic [15:0] alu, input bit cf,
                                input logic [15:0] sd, input logic [2:0] rd, input bit v,
                                input bit e_valid, input bit e_we, input bit e_rden,
                                input bit e_wren, input bit e_br, input logic [2:0] e_flags);
        vec_t r;
        r.s = 0; r.f = 0; r.v = v; r.op = op; r.alu = alu; r.cf = cf; r.sd = sd; r.rd = rd;
        r.e_valid = e_valid; r.e_we = e_we; r.e_rden = e_rden; r.e_wren = e_wren;
        r.e_br = e_br; r.e_flags = e_flags; r.e_res = alu; r.e_sd = sd; r.e_rd = rd;
        return r;
    endfunction

    initial begin
        r_st = 1'b0; stall = 0; flush = 0; ex_valid = 0; ex_ALUCode = T_NOP;
        ex_ALU_out = 0; ex_cf = 0; ex_store_data = 0; ex_rd = 0;
        model_reset();
        @(posedge clock); #1;
        check_all("por");
        check("por result0", 32'(mem_result), 32'h0);
        r_st = 1'b1;

        //               op      alu       cf    sd        rd    v   valid we  rden wren br   flags
        vecs[0]  = mk(T_SUB,   16'h0000, 1'b0, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100);
        vecs[1]  = mk(T_BZ,    16'h0040, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100);
        vecs[2]  = mk(T_ADD,   16'h0000, 1'b1, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101);
        vecs[3]  = mk(T_AND,   16'h8000, 1'b0, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011);
        vecs[4]  = mk(T_BNC,   16'h0123, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011);
        vecs[5]  = mk(T_CMP,   16'hFFFF, 1'b1, 16'h0000, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011);
        vecs[6]  = mk(T_LOAD,  16'h0010, 1'b0, 16'h0000, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b011);
        vecs[7]  = mk(T_STORE, 16'h0020, 1'b0, 16'hBEEF, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011);
        vecs[8]  = mk(T_ADD,   16'h0000, 1'b0, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011);
        vecs[9]  = mk(5'd28,   16'h0000, 1'b0, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011);
        vecs[10] = mk(T_BC,    16'h0044, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011);
        vecs[11] = mk(T_BNZ,   16'h0050, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011);
        vecs[12] = mk(T_SRL,   16'h0001, 1'b0, 16'h0000, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001);

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].s, vecs[i].f, vecs[i].v, vecs[i].op,
                 vecs[i].alu, vecs[i].cf, vecs[i].sd, vecs[i].rd);
            check($sformatf("vec%0d valid", i),  32'(mem_valid),  32'(vecs[i].e_valid));
            check($sformatf("vec%0d we", i),     32'(mem_reg_we), 32'(vecs[i].e_we));
            check($sformatf("vec%0d rd_en", i),  32'(mem_rd_en),  32'(vecs[i].e_rden));
            check($sformatf("vec%0d wr_en", i),  32'(mem_wr_en),  32'(vecs[i].e_wren));
            check($sformatf("vec%0d br", i),     32'(br_taken),   32'(vecs[i].e_br));
            check($sformatf("vec%0d flags", i),  32'(flags),      32'(vecs[i].e_flags));
            check($sformatf("vec%0d cf_to_alu", i), 32'(cf_to_alu), 32'(vecs[i].e_flags[0]));
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d result", i), 32'(mem_result),     32'(vecs[i].e_res));
                check($sformatf("vec%0d target", i), 32'(br_target),      32'(vecs[i].e_res));
                check($sformatf("vec%0d sdata", i),  32'(mem_store_data), 32'(vecs[i].e_sd));
                check($sformatf("vec%0d rd", i),     32'(mem_rd),         32'(vecs[i].e_rd));
            end
        end

        // Taken JUMP then 3 stalled cycles: redirect lasts one cycle, slot held.
        step("jump", 0, 0, 1, T_JUMP, 16'h0100, 0, 16'h0, 3'd0);
        check("jump br", 32'(br_taken), 32'h1);
        check("jump target", 32'(br_target), 32'h0100);
        for (int k = 0; k < 3; k++) begin
            step("stall", 1, 0, 1, T_ADD, 16'h1234, 1, 16'h0, 3'd2);
            check($sformatf("stall%0d br", k),    32'(br_taken),   32'h0);
            check($sformatf("stall%0d result", k), 32'(mem_result), 32'h0100);
            check($sformatf("stall%0d valid", k),  32'(mem_valid),  32'h1);
            check($sformatf("stall%0d flags", k),  32'(flags),      32'b001);
        end
        step("flush+stall", 1, 1, 1, T_ADD, 16'h1234, 1, 16'h0, 3'd2);
        check("flush valid", 32'(mem_valid),  32'h0);
        check("flush we",    32'(mem_reg_we), 32'h0);
        check("flush flags", 32'(flags),      32'b001);

        // LOAD in flight, then reset dropped mid-cycle.
        step("load", 0, 0, 1, T_LOAD, 16'h0030, 0, 16'h0, 3'd3);
        check_all("load");
        do_reset("midrst");

        // HALT: sticky, later instructions ignored, stall ignored.
        step("halt", 0, 0, 1, T_HALT, 16'h0000, 0, 16'h0, 3'd0);
        check("halt valid",  32'(mem_valid),  32'h1);
        check("halt halted", 32'(halted),     32'h1);
        check("halt we",     32'(mem_reg_we), 32'h0);
        step("post-halt add", 0, 0, 1, T_ADD, 16'h0000, 1, 16'h0, 3'd1);
        check("post-halt valid", 32'(mem_valid), 32'h0);
        check("post-halt flags", 32'(flags),     32'b000);
        step("post-halt stall", 1, 0, 1, T_SUB, 16'h8000, 1, 16'h0, 3'd1);
        check_all("post-halt stall");
`ifdef EXMEM_PERF_CNT_EN
        check("halt perf_retired", 32'(perf_retired), 32'h1);
`endif
        do_reset("halt-rst");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [4:0] op;
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0)
                do_reset("rrst");
            op = 5'($urandom_range(0, 31));
            if (op == T_HALT && $urandom_range(0, 9) != 0) op = T_ADDC;
            step("rand", $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 85, op,
                 ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
                 1'($urandom), 16'($urandom), 3'($urandom));
            check_all($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
